// File: rtl/median_stream_finder.sv
// Streaming median finder: loads N samples over a valid/ready handshake, sorts them
// with an odd-even transposition network (one pass per cycle), then presents the median.
module median_stream_finder #(
  parameter int WIDTH = 4,
  parameter int N     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] median,
  output logic             busy
);

  localparam int CW  = $clog2(N + 1);
  localparam int MID = (N - 1) / 2;

  if ((N % 2) == 0 || N < 3 || N > 15) begin : g_bad_n
    $error("median_stream_finder: N must be odd and within 3..15");
  end

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sample_buf [N];
  logic [WIDTH-1:0] pass_out   [N];
  logic [CW-1:0]    load_cnt;
  logic [CW-1:0]    pass_cnt;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = rst_n;
        if (in_valid && rst_n && load_cnt == CW'(N - 1)) state_next = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (pass_cnt == CW'(N - 1)) state_next = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // One transposition pass: pairs start at index 0 on even passes, index 1 on odd.
  always_comb begin
    pass_out = sample_buf;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == pass_cnt[0] && sample_buf[i] > sample_buf[i+1]) begin
        pass_out[i]   = sample_buf[i+1];
        pass_out[i+1] = sample_buf[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sample_buf[i] <= '0;
      load_cnt <= '0;
      pass_cnt <= '0;
      median   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            sample_buf[load_cnt] <= in_data;
            load_cnt             <= load_cnt + 1'b1;
            if (load_cnt == CW'(N - 1)) pass_cnt <= '0;
          end
        end
        SORT: begin
          sample_buf <= pass_out;
          pass_cnt   <= pass_cnt + 1'b1;
          if (pass_cnt == CW'(N - 1)) median <= pass_out[MID];
        end
        OUT: begin
          if (out_ready) load_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median_stream_finder.sv
// Directed self-checking bench for median_stream_finder at N=5/WIDTH=4 and N=7/WIDTH=8.
module tb_median_stream_finder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_in_valid = 1'b0;
  logic [3:0] a_in_data = '0;
  logic       a_in_ready;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic [3:0] a_median;
  logic       a_busy;

  logic       b_in_valid = 1'b0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic [7:0] b_median;
  logic       b_busy;

  int pass_count  = 0;
  int total_count = 0;
  int cyc = 0;
  int t1, t2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  median_stream_finder #(.WIDTH(4), .N(5)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .median(a_median), .busy(a_busy)
  );

  median_stream_finder #(.WIDTH(8), .N(7)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .median(b_median), .busy(b_busy)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [19:0] v);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = v[19-4*i -: 4];
      tick();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic apply_stimulus_b(input logic [55:0] v);
    for (int i = 0; i < 7; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = v[55-8*i -: 8];
      tick();
    end
  endtask

  // Four sort edges leave out_valid low, the fifth raises it with the median.
  task automatic expect_median_a(input string tag, input logic [3:0] m);
    repeat (4) tick();
    check_output({tag, "_early"}, a_out_valid, 0);
    tick();
    check_output({tag, "_valid"}, a_out_valid, 1);
    check_output({tag, "_median"}, a_median, m);
  endtask

  task automatic handshake_a(input string tag);
    a_out_ready = 1'b1;
    tick();
    check_output({tag, "_pulse_end"}, a_out_valid, 0);
    check_output({tag, "_in_ready"}, a_in_ready, 1);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    #1;
    check_output("rst_in_ready", a_in_ready, 1);
    check_output("rst_out_valid", a_out_valid, 0);
    check_output("rst_busy", a_busy, 0);
    check_output("rst_median", a_median, 0);

    a_out_ready = 1'b1;
    apply_stimulus({4'd3, 4'd9, 4'd1, 4'd7, 4'd5});
    check_output("basic_busy", a_busy, 1);
    check_output("basic_in_ready", a_in_ready, 0);
    expect_median_a("basic", 4'd5);
    handshake_a("basic");

    apply_stimulus({4'd4, 4'd4, 4'd4, 4'd2, 4'd9});
    expect_median_a("dup", 4'd4);
    handshake_a("dup");

    apply_stimulus({4'd15, 4'd0, 4'd15, 4'd0, 4'd15});
    expect_median_a("extreme", 4'd15);
    handshake_a("extreme");

    apply_stimulus({4'd15, 4'd12, 4'd8, 4'd3, 4'd0});
    expect_median_a("desc", 4'd8);
    handshake_a("desc");

    a_out_ready = 1'b0;
    apply_stimulus({4'd1, 4'd14, 4'd7, 4'd11, 4'd0});
    expect_median_a("bp", 4'd7);
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 4'd13;
      tick();
      check_output("bp_hold_valid", a_out_valid, 1);
      check_output("bp_hold_median", a_median, 7);
      check_output("bp_hold_in_ready", a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    handshake_a("bp");

    begin
      logic [7:0]  gv;
      logic [31:0] gd;
      gv = 8'b1001_1011;
      gd = {4'd6, 4'hx, 4'hx, 4'd2, 4'd8, 4'hx, 4'd4, 4'd10};
      for (int i = 0; i < 8; i++) begin
        a_in_valid = gv[7-i];
        a_in_data  = gd[31-4*i -: 4];
        tick();
      end
      a_in_valid = 1'b0;
    end
    check_output("gap_busy", a_busy, 1);
    expect_median_a("gap", 4'd6);
    handshake_a("gap");

    apply_stimulus({4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("midsort_rst_out_valid", a_out_valid, 0);
    check_output("midsort_rst_busy", a_busy, 0);
    check_output("midsort_rst_median", a_median, 0);
    #2 rst_n = 1'b1;
    apply_stimulus({4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    expect_median_a("post_rst", 4'd3);
    handshake_a("post_rst");

    b_out_ready = 1'b1;
    apply_stimulus_b({8'd200, 8'd17, 8'd255, 8'd0, 8'd128, 8'd64, 8'd99});
    b_in_data = 8'd1;
    repeat (6) tick();
    check_output("n7_early", b_out_valid, 0);
    tick();
    check_output("n7_valid", b_out_valid, 1);
    check_output("n7_median", b_median, 99);
    t1 = cyc;
    tick();
    check_output("n7_pulse_end", b_out_valid, 0);
    apply_stimulus_b({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70});
    b_in_data = 8'd2;
    repeat (7) tick();
    check_output("n7b_valid", b_out_valid, 1);
    check_output("n7b_median", b_median, 40);
    t2 = cyc;
    check_output("n7_period", t2 - t1, 15);
    b_in_valid = 1'b0;

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
